multicycle_controller: RTL and testbench

//  Main control FSM for the multi-cycle RV32 datapath. It is the driving end of the ALU interface.
//  Per state it issues the 4-bit ALU op code and the operand selects, and it consumes the ALU zero flag for branches.
//  It sequences fetch/decode/execute/memory/writeback, drives all datapath strobes and flags illegal instructions.

---
 rtl/riscv_ctrl_pkg.sv | 59 +++++
 rtl/alu_op_decoder.sv | 33 +++
 rtl/multicycle_controller.sv | 118 +++++++++++
 tb/tb_multicycle_controller.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32 control path: FSM states, opcodes,
// ALU op codes (also used by the ALU) and immediate format selects.
package riscv_ctrl_pkg;

  localparam int OPC_W = 7;
  localparam int AOP_W = 4;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALU_WB,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_JALR_LINK,
    S_LUI,
    S_ILLEGAL
  } state_t;

  localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_IMM    = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;

  localparam logic [AOP_W-1:0] ALU_ADD = 4'b0000;
  localparam logic [AOP_W-1:0] ALU_SUB = 4'b0001;
  localparam logic [AOP_W-1:0] ALU_AND = 4'b0010;
  localparam logic [AOP_W-1:0] ALU_OR  = 4'b0011;
  localparam logic [AOP_W-1:0] ALU_SLT = 4'b0101;
  localparam logic [AOP_W-1:0] ALU_SLL = 4'b0110;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Immediate format follows the instruction class; anything else defaults to I.
  function automatic logic [2:0] imm_src_of(input logic [OPC_W-1:0] opcode);
    case (opcode)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      OP_LUI:    return IMM_U;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Maps funct3/funct7_5 of R-type and I-type ALU instructions to an ALU op code
// and reports whether the funct combination is supported.
module alu_op_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             is_rtype,
  input  logic             is_itype,
  output logic [AOP_W-1:0] alu_op,
  output logic             funct_legal
);

  // instr[30] only selects SUB for R-type; for I-type it is part of the immediate.
  always_comb begin
    alu_op      = ALU_ADD;
    funct_legal = 1'b1;
    if (is_rtype || is_itype) begin
      case (funct3)
        3'b000: alu_op = (is_rtype && funct7_5) ? ALU_SUB : ALU_ADD;
        3'b111: alu_op = ALU_AND;
        3'b110: alu_op = ALU_OR;
        3'b010: alu_op = ALU_SLT;
        3'b001: begin
          alu_op = ALU_SLL;
          if (is_rtype && funct7_5) funct_legal = 1'b0;
        end
        default: funct_legal = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle RV32 datapath: sequences each instruction
// and drives datapath strobes, operand selects and the ALU op code.
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPC_W-1:0] opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             zero,
  output logic             pc_write,
  output logic             adr_src,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [AOP_W-1:0] alu_op,
  output logic [2:0]       imm_src,
  output logic             illegal,
  output logic             instr_done
);

  state_t           state_q, state_d;
  logic [AOP_W-1:0] dec_alu_op;
  logic             funct_legal;

  alu_op_decoder u_alu_op_decoder (
    .funct3      (funct3),
    .funct7_5    (funct7_5),
    .is_rtype    (opcode == OP_R),
    .is_itype    (opcode == OP_IMM),
    .alu_op      (dec_alu_op),
    .funct_legal (funct_legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = (funct3 == 3'b010) ? S_MEM_ADR : S_ILLEGAL;
          OP_R:      state_d = funct_legal ? S_EXEC_R : S_ILLEGAL;
          OP_IMM:    state_d = funct_legal ? S_EXEC_I : S_ILLEGAL;
          OP_BRANCH: state_d = (funct3[2:1] == 2'b00) ? S_BRANCH : S_ILLEGAL;
          OP_JAL:    state_d = S_JAL;
          OP_JALR:   state_d = S_JALR;
          OP_LUI:    state_d = S_LUI;
          default:   state_d = S_ILLEGAL;
        endcase
      end
      S_MEM_ADR:  state_d = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ: state_d = S_MEM_WB;
      S_EXEC_R,
      S_EXEC_I,
      S_JAL:      state_d = S_ALU_WB;
      S_JALR:     state_d = S_JALR_LINK;
      default:    state_d = S_FETCH;
    endcase
  end

  // Outputs are held at zero while reset is asserted, even though state is FETCH.
  always_comb begin
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = ALU_ADD;
    illegal    = 1'b0;
    instr_done = 1'b0;
    imm_src    = imm_src_of(opcode);
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          ir_write = 1'b1; alu_src_b = 2'b10; result_src = 2'b10; pc_write = 1'b1;
        end
        S_DECODE:    begin alu_src_a = 2'b01; alu_src_b = 2'b01; end
        S_MEM_ADR:   begin alu_src_a = 2'b10; alu_src_b = 2'b01; end
        S_MEM_READ:  adr_src = 1'b1;
        S_MEM_WB:    begin result_src = 2'b01; reg_write = 1'b1; instr_done = 1'b1; end
        S_MEM_WRITE: begin adr_src = 1'b1; mem_write = 1'b1; instr_done = 1'b1; end
        S_EXEC_R:    begin alu_src_a = 2'b10; alu_op = dec_alu_op; end
        S_EXEC_I:    begin alu_src_a = 2'b10; alu_src_b = 2'b01; alu_op = dec_alu_op; end
        S_ALU_WB:    begin reg_write = 1'b1; instr_done = 1'b1; end
        S_BRANCH: begin
          alu_src_a  = 2'b10;
          alu_op     = ALU_SUB;
          pc_write   = funct3[0] ? ~zero : zero;
          instr_done = 1'b1;
        end
        S_JAL:       begin alu_src_a = 2'b01; alu_src_b = 2'b10; pc_write = 1'b1; end
        S_JALR: begin
          alu_src_a = 2'b10; alu_src_b = 2'b01; result_src = 2'b10; pc_write = 1'b1;
        end
        S_JALR_LINK: begin
          alu_src_a = 2'b01; alu_src_b = 2'b10; result_src = 2'b10;
          reg_write = 1'b1; instr_done = 1'b1;
        end
        S_LUI:       begin result_src = 2'b11; reg_write = 1'b1; instr_done = 1'b1; end
        S_ILLEGAL:   begin illegal = 1'b1; instr_done = 1'b1; end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed and random instructions
// compared cycle by cycle against an instruction-level reference model.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       zero;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal, instr_done;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [3:0] alu_op;
  logic [2:0] imm_src;

  int vectors     = 0;
  int miscompares = 0;

  typedef enum {K_LW, K_SW, K_ALUR, K_ALUI, K_BEQ, K_BNE, K_JAL, K_JALR, K_LUI, K_BAD} kind_e;

  multicycle_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct3     (funct3),
    .funct7_5   (funct7_5),
    .zero       (zero),
    .pc_write   (pc_write),
    .adr_src    (adr_src),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .result_src (result_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .imm_src    (imm_src),
    .illegal    (illegal),
    .instr_done (instr_done)
  );

  always #5 clk = ~clk;

  logic [16:0] got;
  assign got = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                alu_src_a, alu_src_b, alu_op, illegal, instr_done};

  function automatic logic [16:0] mkvec(input logic pcw, input logic adr, input logic mw,
                                        input logic irw, input logic rw, input logic [1:0] rs,
                                        input logic [1:0] a, input logic [1:0] b,
                                        input logic [3:0] op, input logic ill, input logic done);
    return {pcw, adr, mw, irw, rw, rs, a, b, op, ill, done};
  endfunction

  // Returns 4'hF for funct combinations the ISA subset does not support.
  function automatic logic [3:0] ref_aluop(input bit rtype, input logic [2:0] f3, input logic f75);
    case (f3)
      3'b000:  return (rtype && f75) ? 4'b0001 : 4'b0000;
      3'b111:  return 4'b0010;
      3'b110:  return 4'b0011;
      3'b010:  return 4'b0101;
      3'b001:  return (rtype && f75) ? 4'hF : 4'b0110;
      default: return 4'hF;
    endcase
  endfunction

  function automatic kind_e classify(input logic [6:0] op, input logic [2:0] f3, input logic f75);
    case (op)
      7'b0000011: return (f3 == 3'b010) ? K_LW : K_BAD;
      7'b0100011: return (f3 == 3'b010) ? K_SW : K_BAD;
      7'b0110011: return (ref_aluop(1'b1, f3, f75) != 4'hF) ? K_ALUR : K_BAD;
      7'b0010011: return (ref_aluop(1'b0, f3, f75) != 4'hF) ? K_ALUI : K_BAD;
      7'b1100011: return (f3 == 3'b000) ? K_BEQ : (f3 == 3'b001) ? K_BNE : K_BAD;
      7'b1101111: return K_JAL;
      7'b1100111: return K_JALR;
      7'b0110111: return K_LUI;
      default:    return K_BAD;
    endcase
  endfunction

  function automatic int cpi(input kind_e k);
    case (k)
      K_LW:                 return 5;
      K_BEQ, K_BNE, K_LUI,
      K_BAD:                return 3;
      default:              return 4;
    endcase
  endfunction

  function automatic logic [2:0] ref_imm(input logic [6:0] op);
    case (op)
      7'b0100011: return 3'b001;
      7'b1100011: return 3'b010;
      7'b1101111: return 3'b011;
      7'b0110111: return 3'b100;
      default:    return 3'b000;
    endcase
  endfunction

  // Expected outputs for cycle c (0 = fetch) of an instruction of kind k.
  function automatic logic [16:0] ref_cycle(input kind_e k, input int c, input logic [2:0] f3,
                                            input logic f75, input logic z);
    logic [16:0] wb;
    wb = mkvec(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 4'h0, 0, 1);
    if (c == 0) return mkvec(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 4'h0, 0, 0);
    if (c == 1) return mkvec(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 4'h0, 0, 0);
    case (k)
      K_LW, K_SW: begin
        if (c == 2) return mkvec(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 4'h0, 0, 0);
        if (k == K_SW) return mkvec(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 4'h0, 0, 1);
        if (c == 3) return mkvec(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'h0, 0, 0);
        return mkvec(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 4'h0, 0, 1);
      end
      K_ALUR: return (c == 2) ? mkvec(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, ref_aluop(1'b1, f3, f75), 0, 0) : wb;
      K_ALUI: return (c == 2) ? mkvec(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, ref_aluop(1'b0, f3, f75), 0, 0) : wb;
      K_BEQ:  return mkvec(z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 4'h1, 0, 1);
      K_BNE:  return mkvec(!z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 4'h1, 0, 1);
      K_JAL:  return (c == 2) ? mkvec(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 4'h0, 0, 0) : wb;
      K_JALR: begin
        if (c == 2) return mkvec(1, 0, 0, 0, 0, 2'b10, 2'b10, 2'b01, 4'h0, 0, 0);
        return mkvec(0, 0, 0, 0, 1, 2'b10, 2'b01, 2'b10, 4'h0, 0, 1);
      end
      K_LUI:  return mkvec(0, 0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 4'h0, 0, 1);
      default: return mkvec(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'h0, 1, 1);
    endcase
  endfunction

  // Runs one whole instruction starting in fetch; zmode < 0 randomizes zero each cycle.
  task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic f75, input int zmode);
    kind_e       k;
    logic [16:0] exp_v;
    k = classify(op, f3, f75);
    opcode = op; funct3 = f3; funct7_5 = f75;
    for (int c = 0; c < cpi(k); c++) begin
      zero = (zmode < 0) ? 1'($urandom) : zmode[0];
      @(negedge clk);
      exp_v = ref_cycle(k, c, f3, f75, zero);
      vectors++;
      if (got !== exp_v) begin
        miscompares++;
        $display("[TB] FAIL %s cycle%0d outputs: got %h want %h", name, c, got, exp_v);
      end
      vectors++;
      if (imm_src !== ref_imm(op)) begin
        miscompares++;
        $display("[TB] FAIL %s cycle%0d imm_src: got %b want %b", name, c, imm_src, ref_imm(op));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; opcode = 7'b0110011; funct3 = 3'b000; funct7_5 = 1'b0; zero = 1'b1;
    @(negedge clk);
    vectors++;
    if (got !== 17'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_idle: got %h want %h", got, 17'h0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_instr("post_reset_add", 7'b0110011, 3'b000, 1'b0, -1);
  endtask

  task automatic test_reset_mid();
    opcode = 7'b0110011; funct3 = 3'b000; funct7_5 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    vectors++;
    if (got !== mkvec(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 4'h0, 0, 0)) begin
      miscompares++;
      $display("[TB] FAIL mid_exec_r: got %h want EXEC_R add outputs", got);
    end
    rst_n = 1'b0; #1;
    vectors++;
    if (got !== 17'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_async: got %h want %h", got, 17'h0);
    end
    @(posedge clk); #1;
    vectors++;
    if (got !== 17'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_held: got %h want %h", got, 17'h0);
    end
    rst_n = 1'b1;
    run_instr("after_mid_reset", 7'b0110011, 3'b000, 1'b0, -1);
  endtask

  task automatic test_alu();
    run_instr("add",  7'b0110011, 3'b000, 1'b0, -1);
    run_instr("sub",  7'b0110011, 3'b000, 1'b1, -1);
    run_instr("and",  7'b0110011, 3'b111, 1'b0, -1);
    run_instr("slti", 7'b0010011, 3'b010, 1'b1, -1);
    run_instr("slli", 7'b0010011, 3'b001, 1'b0, -1);
    run_instr("ori",  7'b0010011, 3'b110, 1'b0, -1);
  endtask

  task automatic test_branch();
    run_instr("beq_taken",    7'b1100011, 3'b000, 1'b0, 1);
    run_instr("beq_nottaken", 7'b1100011, 3'b000, 1'b0, 0);
    run_instr("bne_taken",    7'b1100011, 3'b001, 1'b0, 0);
    run_instr("bne_nottaken", 7'b1100011, 3'b001, 1'b0, 1);
  endtask

  task automatic test_mem_jump();
    run_instr("lw",   7'b0000011, 3'b010, 1'b0, -1);
    run_instr("sw",   7'b0100011, 3'b010, 1'b0, -1);
    run_instr("jal",  7'b1101111, 3'b101, 1'b1, -1);
    run_instr("jalr", 7'b1100111, 3'b000, 1'b0, -1);
    run_instr("lui",  7'b0110111, 3'b011, 1'b0, -1);
  endtask

  task automatic test_illegal();
    run_instr("op_7f",     7'b1111111, 3'b000, 1'b0, -1);
    run_instr("r_f3_101",  7'b0110011, 3'b101, 1'b0, -1);
    run_instr("sll_f7",    7'b0110011, 3'b001, 1'b1, -1);
    run_instr("lw_f3_bad", 7'b0000011, 3'b000, 1'b0, -1);
    run_instr("br_f3_bad", 7'b1100011, 3'b100, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    logic [6:0] op;
    logic [2:0] f3;
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 9))
        0: op = 7'b0000011; 1: op = 7'b0100011; 2: op = 7'b0110011; 3: op = 7'b0010011;
        4: op = 7'b1100011; 5: op = 7'b1101111; 6: op = 7'b1100111; 7: op = 7'b0110111;
        default: op = 7'($urandom);
      endcase
      f3 = 3'($urandom);
      if ((op == 7'b0000011 || op == 7'b0100011) && ($urandom_range(0, 3) != 0)) f3 = 3'b010;
      run_instr("random", op, f3, 1'($urandom), -1);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_reset_mid();
    test_alu();
    test_branch();
    test_mem_jump();
    test_illegal();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
